reg_bank_mp: RTL and testbench
==============================

Name: reg_bank_mp

Overview:
Parametrised multi-port successor to the datapath register bank. It feeds operands to the ALU and controller path. It provides N registers of configurable width, lane-granular partial writes, NRD registered read ports with per-port enable and constant override, and same-cycle write-to-read bypass. It also runs a multi-cycle hardware clear sweep with a busy flag, so the controller can reinitialise the bank without issuing 16 writes.

Parameters:
DATA_W, 64, register and port data width
NREGS, 16, number of registers (power of two, >=2)
LANES, 4, write lanes per register; LANE_W = DATA_W/LANES, must divide exactly
NRD, 2, number of read ports
CONST_VAL, 64'h0, value driven on a read port when its cnst bit is set
ADDR_W, $clog2(NREGS), derived register address width
LSEL_W, max(1,$clog2(LANES)), derived lane-select width

Ports:
clock  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
regwen  in  1  write enable
wmode  in  1  0 = full-word write, 1 = single-lane write
selwreg  in  ADDR_W  write register address
endwreg  in  LSEL_W  lane index for lane writes; ignored when wmode=0
inA  in  DATA_W  write data; lane writes use inA[LANE_W-1:0]
selout  in  NRD*ADDR_W  packed read addresses; port k uses slice k
enrreg  in  NRD  per-port read enable
cnst  in  NRD  per-port constant override
outs  out  NRD*DATA_W  packed registered read data; port k uses slice k
clr_req  in  1  starts a clear sweep
busy  out  1  high while a clear sweep is running
clr_done  out  1  one-cycle pulse in the cycle busy falls

Behaviour:
- Reset (reset=1 at a clock edge): all registers are 0, all outs are 0, busy=0, clr_done=0, and the sweep counter is 0. Reset overrides every other input, including reset asserted in the middle of a sweep.
- Full write: regwen=1, wmode=0, busy=0. reg[selwreg] takes inA at the edge.
- Lane write: regwen=1, wmode=1, busy=0. Only bits [endwreg*LANE_W +: LANE_W] of reg[selwreg] take inA[LANE_W-1:0]. All other bits hold.
- Writes are ignored while busy=1, and in the same cycle that clr_req is accepted.
- Read port k has 1-cycle latency. At each edge:
  - if cnst[k]=1, out_k = CONST_VAL (priority over enrreg);
  - else if enrreg[k]=1, out_k = the merged value of reg[selout_k];
  - else out_k holds.
- Bypass: if a write to address a is accepted in the same cycle that port k reads address a, out_k receives the post-write merged value. For a lane write, that is the old word with the new lane inserted. Ports never return stale data.
- Several ports may read the same address in the same cycle.
- Clear FSM states: IDLE, SWEEP.
  - IDLE: clr_req=1 moves to SWEEP with cnt=0 and busy=1 on the next cycle.
  - SWEEP: each cycle reg[cnt] becomes 0 and cnt increments. Exactly NREGS cycles are spent in SWEEP.
  - On the edge that clears reg[NREGS-1], the FSM returns to IDLE and busy falls. clr_done=1 for that one following cycle.
- clr_req while busy=1 is ignored, with no restart.
- Reads during SWEEP are legal. If the read address equals the register being cleared that cycle, the port returns 0 (bypass applies to the clear as well).
- The write address and read addresses are always in range, because NREGS is a power of two. Counter wrap is not reachable, because exit occurs at NREGS-1.

Test Plan:
- Reset and full write/read: write 0xAB01C4A0_00000010 to r5, then set selout0=5, enrreg0=1 -> out0 = 0xAB01C4A0_00000010 one edge later; out1 = 0 with enrreg1=0.
- Lane write: with r3 = 0x11112222_33334444, apply wmode=1, endwreg=2, inA=0xBEEF -> r3 = 0x1111BEEF_33334444; lanes 0, 1 and 3 are unchanged.
- Bypass and hold: write 0x5 to r7 while port0 reads r7 and port1 reads r7 with cnst1=1 -> out0=0x5 and out1=CONST_VAL after one edge. Then drop enrreg0 and write 0x9 to r7 -> out0 stays 0x5.
- Clear sweep: fill r0..r15 with i+1 and pulse clr_req -> busy high for exactly 16 cycles, then a single-cycle clr_done. All registers read 0 afterwards. A write of 0xFF to r2 mid-sweep is dropped (r2 reads 0), and a second clr_req mid-sweep does not extend busy.
- Reset mid-sweep: assert reset at sweep cycle 6 -> busy=0 and clr_done=0 next edge; all registers and outs read 0.
- Parameter sweep: NREGS=8, DATA_W=32, LANES=2, NRD=3 -> lane 1 write of 0xCAFE to r6 gives 0xCAFE0000. All three ports reading r6 return the same value, and the sweep lasts 8 cycles.

Source files
------------

// File: rtl/reg_bank_mp.sv
// Multi-port datapath register bank: lane-granular writes, registered read ports
// with constant override and write/clear bypass, plus a hardware clear sweep.
module reg_bank_mp #(
  parameter int                DATA_W    = 64,
  parameter int                NREGS     = 16,
  parameter int                LANES     = 4,
  parameter int                NRD       = 2,
  parameter logic [DATA_W-1:0] CONST_VAL = '0,
  parameter int                ADDR_W    = $clog2(NREGS),
  parameter int                LSEL_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  regwen,
  input  logic                  wmode,
  input  logic [ADDR_W-1:0]     selwreg,
  input  logic [LSEL_W-1:0]     endwreg,
  input  logic [DATA_W-1:0]     inA,
  input  logic [NRD*ADDR_W-1:0] selout,
  input  logic [NRD-1:0]        enrreg,
  input  logic [NRD-1:0]        cnst,
  output logic [NRD*DATA_W-1:0] outs,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  clr_done
);

  localparam int LANE_W = DATA_W / LANES;

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic                  clr_done_q, clr_done_d;
  logic [DATA_W-1:0]     regs_q [NREGS];
  logic [DATA_W-1:0]     regs_d [NREGS];
  logic [NRD*DATA_W-1:0] outs_q, outs_d;
  logic                  wr_ok;
  logic [DATA_W-1:0]     wr_word;

  // Clear-sweep controller.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_done_d = 1'b0;
    wr_ok      = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end else begin
          wr_ok = regwen;
        end
      end
      SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(NREGS - 1)) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Post-write register image; reads index it so writes and clears bypass to the ports.
  always_comb begin
    wr_word = regs_q[selwreg];
    for (int l = 0; l < LANES; l++) begin
      if (!wmode) begin
        wr_word[l*LANE_W +: LANE_W] = inA[l*LANE_W +: LANE_W];
      end else if (endwreg == LSEL_W'(l)) begin
        wr_word[l*LANE_W +: LANE_W] = inA[LANE_W-1:0];
      end
    end
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_ok && selwreg == ADDR_W'(i)) begin
        regs_d[i] = wr_word;
      end
      if (state_q == SWEEP && cnt_q == ADDR_W'(i)) begin
        regs_d[i] = '0;
      end
    end
  end

  always_comb begin
    outs_d = outs_q;
    for (int k = 0; k < NRD; k++) begin
      if (cnst[k]) begin
        outs_d[k*DATA_W +: DATA_W] = CONST_VAL;
      end else if (enrreg[k]) begin
        outs_d[k*DATA_W +: DATA_W] = regs_d[selout[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clr_done_q <= 1'b0;
      outs_q     <= '0;
      // NOTE: the register array is reset because a freshly reset bank must read as zero.
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_done_q <= clr_done_d;
      outs_q     <= outs_d;
      regs_q     <= regs_d;
    end
  end

  assign outs     = outs_q;
  assign busy     = (state_q == SWEEP);
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_reg_bank_mp.sv
// Self-checking bench for reg_bank_mp: vector table plus scoreboarded multi-cycle
// sequences on a default instance and a reduced-parameter instance.
module tb_reg_bank_mp;

  localparam logic [63:0] CV = 64'hC005_7A17_C005_7A17;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic         a_regwen, a_wmode, a_clr_req, a_busy, a_clr_done;
  logic [3:0]   a_selwreg;
  logic [1:0]   a_endwreg, a_enrreg, a_cnst;
  logic [63:0]  a_inA;
  logic [7:0]   a_selout;
  logic [127:0] a_outs;

  logic         p_regwen, p_wmode, p_clr_req, p_busy, p_clr_done;
  logic [2:0]   p_selwreg, p_enrreg, p_cnst;
  logic [0:0]   p_endwreg;
  logic [31:0]  p_inA;
  logic [8:0]   p_selout;
  logic [95:0]  p_outs;

  reg_bank_mp #(.DATA_W(64), .NREGS(16), .LANES(4), .NRD(2), .CONST_VAL(CV)) u_a (
    .clock(clock), .reset(reset), .regwen(a_regwen), .wmode(a_wmode),
    .selwreg(a_selwreg), .endwreg(a_endwreg), .inA(a_inA), .selout(a_selout),
    .enrreg(a_enrreg), .cnst(a_cnst), .outs(a_outs), .clr_req(a_clr_req),
    .busy(a_busy), .clr_done(a_clr_done)
  );

  reg_bank_mp #(.DATA_W(32), .NREGS(8), .LANES(2), .NRD(3)) u_p (
    .clock(clock), .reset(reset), .regwen(p_regwen), .wmode(p_wmode),
    .selwreg(p_selwreg), .endwreg(p_endwreg), .inA(p_inA), .selout(p_selout),
    .enrreg(p_enrreg), .cnst(p_cnst), .outs(p_outs), .clr_req(p_clr_req),
    .busy(p_busy), .clr_done(p_clr_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    int          src;
    logic [63:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        we;
    logic        wm;
    logic [3:0]  wa;
    logic [1:0]  ln;
    logic [63:0] wd;
    logic [3:0]  r0;
    logic [3:0]  r1;
    logic [1:0]  en;
    logic [1:0]  cn;
    logic [63:0] e0;
    logic [63:0] e1;
  } vec_t;
  vec_t vt[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] actual(input int src);
    if (src < 2) return a_outs[src*64 +: 64];
    return {32'h0, p_outs[(src-2)*32 +: 32]};
  endfunction

  task automatic expect_out(input string name, input int src, input logic [63:0] e);
    sb_q.push_back('{name, src, e});
  endtask

  // One clock edge, then score every output expectation queued for it.
  task automatic cycle();
    sb_t e;
    @(posedge clock);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.name, actual(e.src), e.exp);
    end
  endtask

  task automatic a_idle();
    a_regwen = 0; a_wmode = 0; a_selwreg = 0; a_endwreg = 0; a_inA = 0;
    a_selout = 0; a_enrreg = 0; a_cnst = 0; a_clr_req = 0;
  endtask

  task automatic p_idle();
    p_regwen = 0; p_wmode = 0; p_selwreg = 0; p_endwreg = 0; p_inA = 0;
    p_selout = 0; p_enrreg = 0; p_cnst = 0; p_clr_req = 0;
  endtask

  initial begin
    int n;

    vt[0]  = '{1, 0, 4'd5, 2'd0, 64'hAB01C4A0_00000010, 4'd0, 4'd0, 2'b00, 2'b00, 64'h0, 64'h0};
    vt[1]  = '{0, 0, 4'd0, 2'd0, 64'h0, 4'd5, 4'd0, 2'b01, 2'b00, 64'hAB01C4A0_00000010, 64'h0};
    vt[2]  = '{1, 0, 4'd3, 2'd3, 64'h11112222_33334444, 4'd3, 4'd0, 2'b01, 2'b00,
               64'h11112222_33334444, 64'h0};
    vt[3]  = '{1, 1, 4'd3, 2'd2, 64'hFFFFFFFF_FFFFBEEF, 4'd0, 4'd3, 2'b10, 2'b00,
               64'h11112222_33334444, 64'h1111BEEF_33334444};
    vt[4]  = '{0, 0, 4'd0, 2'd0, 64'h0, 4'd3, 4'd5, 2'b11, 2'b00,
               64'h1111BEEF_33334444, 64'hAB01C4A0_00000010};
    vt[5]  = '{1, 1, 4'd5, 2'd0, 64'h1234, 4'd5, 4'd0, 2'b01, 2'b00,
               64'hAB01C4A0_00001234, 64'hAB01C4A0_00000010};
    vt[6]  = '{1, 0, 4'd7, 2'd0, 64'h5, 4'd7, 4'd7, 2'b11, 2'b10, 64'h5, CV};
    vt[7]  = '{1, 0, 4'd7, 2'd0, 64'h9, 4'd7, 4'd7, 2'b00, 2'b00, 64'h5, CV};
    vt[8]  = '{0, 0, 4'd0, 2'd0, 64'h0, 4'd7, 4'd7, 2'b01, 2'b01, CV, CV};
    vt[9]  = '{0, 0, 4'd0, 2'd0, 64'h0, 4'd7, 4'd7, 2'b11, 2'b00, 64'h9, 64'h9};
    vt[10] = '{0, 1, 4'd0, 2'd3, 64'hA5A5, 4'd0, 4'd7, 2'b01, 2'b00, 64'h0, 64'h9};
    vt[11] = '{1, 1, 4'd0, 2'd3, 64'hA5A5, 4'd0, 4'd7, 2'b01, 2'b00, 64'hA5A5_0000_0000_0000, 64'h9};

    reset = 1;
    a_idle();
    p_idle();
    cycle();
    cycle();
    check("reset_out0", a_outs[63:0], 64'h0);
    check("reset_out1", a_outs[127:64], 64'h0);
    check("reset_busy", a_busy, 0);
    check("reset_clr_done", a_clr_done, 0);
    reset = 0;

    // Table-driven single-edge vectors.
    for (int i = 0; i < 12; i++) begin
      a_regwen = vt[i].we; a_wmode = vt[i].wm; a_selwreg = vt[i].wa;
      a_endwreg = vt[i].ln; a_inA = vt[i].wd;
      a_selout = {vt[i].r1, vt[i].r0}; a_enrreg = vt[i].en; a_cnst = vt[i].cn;
      expect_out($sformatf("vec%0d_out0", i), 0, vt[i].e0);
      expect_out($sformatf("vec%0d_out1", i), 1, vt[i].e1);
      cycle();
    end

    // Clear sweep with mid-sweep read, dropped write and ignored re-request.
    a_idle();
    for (int i = 0; i < 16; i++) begin
      a_regwen = 1; a_selwreg = 4'(i); a_inA = 64'(i + 1);
      cycle();
    end
    a_idle();
    a_clr_req = 1;
    cycle();
    check("sweep_busy_start", a_busy, 1);
    check("sweep_done_start", a_clr_done, 0);
    for (int c = 0; c < 16; c++) begin
      a_idle();
      if (c == 2) begin
        a_selout[3:0] = 4'd2; a_enrreg = 2'b01;
        expect_out("sweep_read_being_cleared", 0, 64'h0);
      end
      if (c == 4) begin
        a_selout[7:4] = 4'd10; a_enrreg = 2'b10;
        expect_out("sweep_read_not_yet_cleared", 1, 64'd11);
      end
      if (c == 5) begin
        a_regwen = 1; a_selwreg = 4'd2; a_inA = 64'hFF;
      end
      if (c == 6) a_clr_req = 1;
      cycle();
      check($sformatf("sweep_busy_c%0d", c), a_busy, (c < 15));
      check($sformatf("sweep_done_c%0d", c), a_clr_done, (c == 15));
    end
    a_idle();
    cycle();
    check("sweep_busy_after", a_busy, 0);
    check("sweep_done_pulse_end", a_clr_done, 0);
    for (int i = 0; i < 16; i++) begin
      a_selout[3:0] = 4'(i); a_enrreg = 2'b01;
      expect_out($sformatf("after_sweep_r%0d", i), 0, 64'h0);
      cycle();
    end

    // Reset in the middle of a sweep.
    a_idle();
    a_regwen = 1; a_selwreg = 4'd1; a_inA = 64'h77;
    cycle();
    a_selwreg = 4'd14; a_inA = 64'h88;
    cycle();
    a_idle();
    a_selout = {4'd14, 4'd0}; a_enrreg = 2'b10; a_cnst = 2'b01;
    expect_out("pre_reset_out0", 0, CV);
    expect_out("pre_reset_out1", 1, 64'h88);
    cycle();
    a_idle();
    a_clr_req = 1;
    cycle();
    a_clr_req = 0;
    for (int c = 0; c < 6; c++) cycle();
    reset = 1;
    expect_out("midreset_out0", 0, 64'h0);
    expect_out("midreset_out1", 1, 64'h0);
    cycle();
    check("midreset_busy", a_busy, 0);
    check("midreset_clr_done", a_clr_done, 0);
    reset = 0;
    cycle();
    check("midreset_busy_stays_low", a_busy, 0);
    for (int i = 0; i < 16; i++) begin
      a_selout[7:4] = 4'(i); a_enrreg = 2'b10;
      expect_out($sformatf("after_reset_r%0d", i), 1, 64'h0);
      cycle();
    end
    a_idle();

    // Reduced-parameter instance: 8 x 32-bit, 2 lanes, 3 read ports.
    p_regwen = 1; p_wmode = 1; p_selwreg = 3'd6; p_endwreg = 1'b1; p_inA = 32'h1234CAFE;
    cycle();
    p_idle();
    p_selout = {3'd6, 3'd6, 3'd6}; p_enrreg = 3'b111;
    expect_out("p_lane1_port0", 2, 64'hCAFE0000);
    expect_out("p_lane1_port1", 3, 64'hCAFE0000);
    expect_out("p_lane1_port2", 4, 64'hCAFE0000);
    cycle();
    p_idle();
    p_clr_req = 1;
    cycle();
    p_clr_req = 0;
    check("p_busy_start", p_busy, 1);
    n = 0;
    while (p_busy && n < 40) begin
      n++;
      cycle();
    end
    check("p_sweep_len", 64'(n), 64'd8);
    check("p_clr_done", p_clr_done, 1);
    p_selout = {3'd6, 3'd6, 3'd6}; p_enrreg = 3'b111;
    expect_out("p_cleared_port0", 2, 64'h0);
    expect_out("p_cleared_port1", 3, 64'h0);
    expect_out("p_cleared_port2", 4, 64'h0);
    cycle();
    check("p_clr_done_single", p_clr_done, 0);
    p_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
